// File: rtl/usbdev_aon_suspend_seq.sv
// usbdev_aon_suspend_seq
//
// Always-on sequencer for the suspend/resume handshake between the USB IP and
// the AON wake detector. A level request from software is turned into a
// checked hand-off: suspend_req to the detector, confirmation through
// wake_detect_active, and later a release through wake_ack. A detector wake
// request latches its cause and raises a power-manager wakeup that is held
// until software acknowledges the resume. Every wait on the detector is
// bounded so a stuck detector cannot hang the AON domain.
//
// Ports:
//   clk_aon_i                 AON clock
//   rst_aon_ni                AON reset, asynchronous, active-low
//   sw_suspend_req_aon_i      software suspend request (level, synchronized)
//   sw_wake_ack_aon_i         software resume acknowledge (level, synchronized)
//   wake_detect_active_aon_i  detector is monitoring the bus
//   wake_req_aon_i            detector wake request
//   bus_not_idle_aon_i        detector event: bus activity
//   bus_reset_aon_i           detector event: bus reset
//   sense_lost_aon_i          detector event: VBUS sense lost
//   suspend_req_aon_o         suspend request to the detector
//   wake_ack_aon_o            wake acknowledge to the detector
//   pwr_wakeup_o              wakeup request to the power manager
//   wake_cause_aon_o          latched {sense_lost, bus_reset, bus_not_idle}
//   timeout_err_aon_o         sticky handoff-timeout flag
//   state_aon_o               FSM state, for debug

module usbdev_aon_suspend_seq #(
    parameter int unsigned HandoffTimeout = 64,
    parameter int unsigned ReleaseHold    = 4
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_ni,
    input  logic       sw_suspend_req_aon_i,
    input  logic       sw_wake_ack_aon_i,
    input  logic       wake_detect_active_aon_i,
    input  logic       wake_req_aon_i,
    input  logic       bus_not_idle_aon_i,
    input  logic       bus_reset_aon_i,
    input  logic       sense_lost_aon_i,
    output logic       suspend_req_aon_o,
    output logic       wake_ack_aon_o,
    output logic       pwr_wakeup_o,
    output logic [2:0] wake_cause_aon_o,
    output logic       timeout_err_aon_o,
    output logic [2:0] state_aon_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        ACTIVE  = 3'd2,
        WAKING  = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } state_e;

    localparam int unsigned CntMax   = (HandoffTimeout > ReleaseHold) ? HandoffTimeout : ReleaseHold;
    localparam int unsigned CntWidth = $clog2(CntMax + 1);
    localparam logic [CntWidth-1:0] CntSat      = CntWidth'(CntMax);
    localparam logic [CntWidth-1:0] HandoffLast = CntWidth'(HandoffTimeout - 1);
    localparam logic [CntWidth-1:0] ReleaseLast = CntWidth'(ReleaseHold - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q;
    logic                timeout_set;
    logic [2:0]          cause_q, cause_d;
    logic [2:0]          events;
    logic                suspend_req_q, wake_ack_q, pwr_wakeup_q, timeout_err_q;

    assign events = {sense_lost_aon_i, bus_reset_aon_i, bus_not_idle_aon_i};

    // Next-state and wake-cause logic. Cause is cleared on every entry into ARM
    // so each suspend episode reports only its own wake events.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                // Do not arm while the detector still looks active from before.
                if (sw_suspend_req_aon_i && !wake_detect_active_aon_i) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (wake_detect_active_aon_i) begin
                    state_d = ACTIVE;
                end else if (!sw_suspend_req_aon_i) begin
                    // Abort: the detector may already have latched the request,
                    // so release it through the normal ack path.
                    state_d = ACK;
                end else if (cnt_q == HandoffLast) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end
            end
            ACTIVE: begin
                // A wake request wins over a simultaneous software resume.
                if (wake_req_aon_i) begin
                    state_d = WAKING;
                    cause_d = events;
                end else if (!sw_suspend_req_aon_i) begin
                    state_d = ACK;
                    cause_d = 3'b000;
                end
            end
            WAKING: begin
                // Power-up latency is unbounded, so there is no timeout here.
                cause_d = cause_q | events;
                if (sw_wake_ack_aon_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!wake_detect_active_aon_i) begin
                    state_d = RELEASE;
                end else if (cnt_q == HandoffLast) begin
                    timeout_set = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: begin
                // Hold off re-arming until software has dropped a stale request.
                if ((cnt_q >= ReleaseLast) && !sw_suspend_req_aon_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if ((state_d == ARM) && (state_q != ARM)) begin
            cause_d = 3'b000;
        end
    end

    // State register and the dwell counter; the counter restarts on every
    // state change and saturates instead of wrapping.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CntSat) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

    // Output flops are loaded from the next state so they line up with the
    // state register without any combinational decode on the outputs.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            suspend_req_q <= 1'b0;
            wake_ack_q    <= 1'b0;
            pwr_wakeup_q  <= 1'b0;
            cause_q       <= 3'b000;
            timeout_err_q <= 1'b0;
        end else begin
            suspend_req_q <= (state_d == ARM);
            wake_ack_q    <= (state_d == ACK);
            pwr_wakeup_q  <= (state_d == WAKING);
            cause_q       <= cause_d;
            timeout_err_q <= timeout_err_q | timeout_set;
        end
    end

    assign suspend_req_aon_o = suspend_req_q;
    assign wake_ack_aon_o    = wake_ack_q;
    assign pwr_wakeup_o      = pwr_wakeup_q;
    assign wake_cause_aon_o  = cause_q;
    assign timeout_err_aon_o = timeout_err_q;
    assign state_aon_o       = state_q;

    // Handshake sanity properties.
    a_req_ack_exclusive: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        !(suspend_req_aon_o && wake_ack_aon_o));
    a_wakeup_in_waking: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        pwr_wakeup_o |-> (state_q == WAKING));
    a_outputs_known: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        !$isunknown({suspend_req_aon_o, wake_ack_aon_o, pwr_wakeup_o,
                     wake_cause_aon_o, timeout_err_aon_o, state_aon_o}));

endmodule

// File: tb/tb_usbdev_aon_suspend_seq.sv
// tb_usbdev_aon_suspend_seq
//
// Self-checking bench for usbdev_aon_suspend_seq. A table of per-cycle
// vectors (inputs plus the outputs expected after the next clock edge) walks
// the FSM through its main paths; expected records are queued when a vector
// is driven and popped when the DUT output is sampled. Hand-written sequences
// cover the stale-level guard, the handoff timeout and a mid-operation reset.

module tb_usbdev_aon_suspend_seq;

    logic       clk_aon_i = 1'b0;
    logic       rst_aon_ni;
    logic       sw_suspend_req, sw_wake_ack, wda, wake_req, not_idle, bus_reset, sense_lost;
    logic       suspend_req, wake_ack, pwr_wakeup, timeout_err;
    logic [2:0] wake_cause, state;

    int n_checks = 0;
    int n_pass   = 0;

    // in  = {sus, ack, wda, wreq, not_idle, bus_reset, sense_lost}
    // flg = {suspend_req, wake_ack, pwr_wakeup}
    typedef struct packed {
        logic [6:0] in;
        logic [2:0] st;
        logic [2:0] flg;
        logic [2:0] cause;
        logic       terr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    usbdev_aon_suspend_seq #(.HandoffTimeout(64), .ReleaseHold(4)) dut (
        .clk_aon_i               (clk_aon_i),
        .rst_aon_ni              (rst_aon_ni),
        .sw_suspend_req_aon_i    (sw_suspend_req),
        .sw_wake_ack_aon_i       (sw_wake_ack),
        .wake_detect_active_aon_i(wda),
        .wake_req_aon_i          (wake_req),
        .bus_not_idle_aon_i      (not_idle),
        .bus_reset_aon_i         (bus_reset),
        .sense_lost_aon_i        (sense_lost),
        .suspend_req_aon_o       (suspend_req),
        .wake_ack_aon_o          (wake_ack),
        .pwr_wakeup_o            (pwr_wakeup),
        .wake_cause_aon_o        (wake_cause),
        .timeout_err_aon_o       (timeout_err),
        .state_aon_o             (state)
    );

    always #5 clk_aon_i = ~clk_aon_i;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [6:0] in, input logic [2:0] st, input logic [2:0] flg,
                                input logic [2:0] cause, input logic terr);
        vec_t v;
        v.in = in; v.st = st; v.flg = flg; v.cause = cause; v.terr = terr;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [6:0] in);
        {sw_suspend_req, sw_wake_ack, wda, wake_req, not_idle, bus_reset, sense_lost} = in;
    endtask

    task automatic check_output(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard"}, 8'd0, 8'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " state"}, {5'd0, state}, {5'd0, e.st});
            check({tag, " flags"}, {5'd0, suspend_req, wake_ack, pwr_wakeup}, {5'd0, e.flg});
            check({tag, " cause"}, {5'd0, wake_cause}, {5'd0, e.cause});
            check({tag, " terr"}, {7'd0, timeout_err}, {7'd0, e.terr});
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk_aon_i);
        drive(v.in);
        exp_q.push_back(v);
        @(posedge clk_aon_i);
        #1;
        check_output(tag);
    endtask

    task automatic step(input logic [6:0] in, input logic [2:0] st, input logic [2:0] flg,
                        input logic [2:0] cause, input logic terr, input string tag);
        vec_t v;
        v.in = in; v.st = st; v.flg = flg; v.cause = cause; v.terr = terr;
        apply_stimulus(v, tag);
    endtask

    initial begin
        int hi_cnt;
        bit seen_low;

        // Busy detector blocks arming.
        add(7'b1010000, 3'd0, 3'b000, 3'b000, 1'b0);
        // Normal cycle with bus_not_idle wake.
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0);
        add(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0);
        add(7'b1011100, 3'd3, 3'b001, 3'b001, 1'b0);
        for (int i = 0; i < 4; i++) add(7'b1010000, 3'd3, 3'b001, 3'b001, 1'b0);
        add(7'b0110000, 3'd4, 3'b010, 3'b001, 1'b0);
        add(7'b0010000, 3'd4, 3'b010, 3'b001, 1'b0);
        add(7'b0010000, 3'd4, 3'b010, 3'b001, 1'b0);
        add(7'b0000000, 3'd5, 3'b000, 3'b001, 1'b0);
        for (int i = 0; i < 3; i++) add(7'b0000000, 3'd5, 3'b000, 3'b001, 1'b0);
        add(7'b0000000, 3'd0, 3'b000, 3'b001, 1'b0);
        // Bus reset wake, then sense_lost accumulates.
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0);
        add(7'b1011010, 3'd3, 3'b001, 3'b010, 1'b0);
        add(7'b1010001, 3'd3, 3'b001, 3'b110, 1'b0);
        add(7'b1010000, 3'd3, 3'b001, 3'b110, 1'b0);
        add(7'b0110000, 3'd4, 3'b010, 3'b110, 1'b0);
        add(7'b0000000, 3'd5, 3'b000, 3'b110, 1'b0);
        for (int i = 0; i < 3; i++) add(7'b0000000, 3'd5, 3'b000, 3'b110, 1'b0);
        add(7'b0000000, 3'd0, 3'b000, 3'b110, 1'b0);
        // Software resume from ACTIVE.
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0);
        add(7'b0010000, 3'd4, 3'b010, 3'b000, 1'b0);
        add(7'b0000000, 3'd5, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) add(7'b0000000, 3'd5, 3'b000, 3'b000, 1'b0);
        add(7'b0000000, 3'd0, 3'b000, 3'b000, 1'b0);
        // Abort while arming.
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b0000000, 3'd4, 3'b010, 3'b000, 1'b0);
        add(7'b0000000, 3'd5, 3'b000, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) add(7'b0000000, 3'd5, 3'b000, 3'b000, 1'b0);
        add(7'b0000000, 3'd0, 3'b000, 3'b000, 1'b0);
        // Wake request beats a simultaneous software resume.
        add(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0);
        add(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0);
        add(7'b0011001, 3'd3, 3'b001, 3'b100, 1'b0);
        add(7'b0110000, 3'd4, 3'b010, 3'b100, 1'b0);
        add(7'b0000000, 3'd5, 3'b000, 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) add(7'b0000000, 3'd5, 3'b000, 3'b100, 1'b0);
        add(7'b0000000, 3'd0, 3'b000, 3'b100, 1'b0);

        // Reset state.
        rst_aon_ni = 1'b0;
        drive(7'b0000000);
        #12;
        check("reset state", {5'd0, state}, 8'd0);
        check("reset outputs", {3'd0, suspend_req, wake_ack, pwr_wakeup, timeout_err, 1'b0}, 8'd0);
        @(negedge clk_aon_i);
        rst_aon_ni = 1'b1;

        foreach (vecs[i]) apply_stimulus(vecs[i], $sformatf("row%0d", i));

        // Stale-level guard: request held high through RELEASE.
        step(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b0, "stale arm");
        step(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b0, "stale active");
        step(7'b1011100, 3'd3, 3'b001, 3'b001, 1'b0, "stale waking");
        step(7'b1110000, 3'd4, 3'b010, 3'b001, 1'b0, "stale ack");
        step(7'b1000000, 3'd5, 3'b000, 3'b001, 1'b0, "stale release");
        for (int i = 0; i < 8; i++) step(7'b1000000, 3'd5, 3'b000, 3'b001, 1'b0, $sformatf("stale hold%0d", i));
        step(7'b0000000, 3'd0, 3'b000, 3'b001, 1'b0, "stale drop");

        // Handoff timeout: detector never confirms.
        @(negedge clk_aon_i);
        drive(7'b1000000);
        hi_cnt = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 200 && !seen_low; i++) begin
            @(posedge clk_aon_i);
            #1;
            if (suspend_req) hi_cnt++;
            else if (hi_cnt > 0) seen_low = 1'b1;
        end
        check("timeout seen end", {7'd0, seen_low}, 8'd1);
        check("timeout req cycles", hi_cnt[7:0], 8'd64);
        check("timeout state", {5'd0, state}, 8'd0);
        check("timeout err", {7'd0, timeout_err}, 8'd1);
        step(7'b0000000, 3'd0, 3'b000, 3'b000, 1'b1, "timeout idle");

        // Reset in WAKING drops everything without a clock edge.
        step(7'b1000000, 3'd1, 3'b100, 3'b000, 1'b1, "rst arm");
        step(7'b1010000, 3'd2, 3'b000, 3'b000, 1'b1, "rst active");
        step(7'b1011010, 3'd3, 3'b001, 3'b010, 1'b1, "rst waking");
        @(negedge clk_aon_i);
        #2;
        rst_aon_ni = 1'b0;
        #1;
        check("async rst state", {5'd0, state}, 8'd0);
        check("async rst flags", {4'd0, suspend_req, wake_ack, pwr_wakeup, timeout_err}, 8'd0);
        check("async rst cause", {5'd0, wake_cause}, 8'd0);
        @(negedge clk_aon_i);
        drive(7'b0000000);
        rst_aon_ni = 1'b1;
        step(7'b0000000, 3'd0, 3'b000, 3'b000, 1'b0, "post rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
